// File: rtl/xor_training_sequencer.sv
// xor_training_sequencer
// On-chip stimulus and scoring stage for the XOR NeuralNetwork block.
// After a start pulse it pulses weight initialisation, walks the four XOR
// samples for EPOCHS training passes, then switches the network into
// inference mode and counts how many of the four samples it classifies
// correctly. Every output is a register, so the network sees glitch-free
// stimulus.

module xor_training_sequencer #(
    parameter int INIT_CYCLES = 4,
    parameter int HOLD_CYCLES = 10,
    parameter int EPOCHS      = 5,
    parameter int TEST_HOLD   = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [1:0]  predicted,
    input  logic [1:0]  expected,
    output logic        reset_value,
    output logic        test_flag,
    output logic        x_input,
    output logic        y_input,
    output logic        sample_strobe,
    output logic        busy,
    output logic        done,
    output logic [15:0] epoch_count,
    output logic [2:0]  test_correct,
    output logic        test_pass
);

    typedef enum logic [2:0] {
        IDLE,
        INIT,
        TRAIN,
        TEST,
        DONE
    } state_t;

    // Terminal values of the shared hold counter for each phase.
    localparam logic [31:0] INIT_LAST    = 32'(INIT_CYCLES - 1);
    localparam logic [31:0] HOLD_LAST    = 32'(HOLD_CYCLES - 1);
    localparam logic [31:0] TEST_LAST    = 32'(TEST_HOLD - 1);
    localparam logic [15:0] EPOCH_TARGET = 16'(EPOCHS);

    state_t      state;
    logic [31:0] hold_cnt;
    logic [1:0]  idx;

    logic        enter_init;
    logic [1:0]  idx_next;
    logic [15:0] epoch_next;
    logic        sample_hit;
    logic [2:0]  correct_next;

    // Next-value helpers: start acceptance, sample advance, epoch and score increments.
    always_comb begin
        enter_init   = start && ((state == IDLE) || (state == DONE));
        idx_next     = idx + 2'd1;
        epoch_next   = epoch_count + 16'd1;
        sample_hit   = (predicted == expected);
        correct_next = test_correct;
        if (sample_hit && (test_correct != 3'd4)) begin
            correct_next = test_correct + 3'd1;
        end
    end

    // Sequencer FSM with all network-facing and status outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= IDLE;
            hold_cnt      <= '0;
            idx           <= '0;
            reset_value   <= 1'b0;
            test_flag     <= 1'b0;
            x_input       <= 1'b0;
            y_input       <= 1'b0;
            sample_strobe <= 1'b0;
            busy          <= 1'b0;
            done          <= 1'b0;
            epoch_count   <= '0;
            test_correct  <= '0;
            test_pass     <= 1'b0;
        end else if (enter_init) begin
            state         <= INIT;
            hold_cnt      <= '0;
            idx           <= '0;
            reset_value   <= 1'b1;
            test_flag     <= 1'b0;
            x_input       <= 1'b0;
            y_input       <= 1'b0;
            sample_strobe <= 1'b0;
            busy          <= 1'b1;
            done          <= 1'b0;
            epoch_count   <= '0;
            test_correct  <= '0;
            test_pass     <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    if (hold_cnt == INIT_LAST) begin
                        state       <= TRAIN;
                        hold_cnt    <= '0;
                        idx         <= '0;
                        reset_value <= 1'b0;
                        x_input     <= 1'b0;
                        y_input     <= 1'b0;
                    end else begin
                        hold_cnt <= hold_cnt + 32'd1;
                    end
                end

                TRAIN: begin
                    if (hold_cnt == HOLD_LAST) begin
                        hold_cnt      <= '0;
                        sample_strobe <= 1'b0;
                        idx           <= idx_next;
                        x_input       <= idx_next[0];
                        y_input       <= idx_next[1];
                        if (idx == 2'd3) begin
                            epoch_count <= epoch_next;
                            if (epoch_next == EPOCH_TARGET) begin
                                state     <= TEST;
                                test_flag <= 1'b1;
                            end
                        end
                    end else begin
                        hold_cnt      <= hold_cnt + 32'd1;
                        sample_strobe <= ((hold_cnt + 32'd1) == HOLD_LAST);
                    end
                end

                TEST: begin
                    if (hold_cnt == TEST_LAST) begin
                        hold_cnt      <= '0;
                        sample_strobe <= 1'b0;
                        test_correct  <= correct_next;
                        idx           <= idx_next;
                        x_input       <= idx_next[0];
                        y_input       <= idx_next[1];
                        if (idx == 2'd3) begin
                            state     <= DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            test_flag <= 1'b0;
                            test_pass <= (correct_next == 3'd4);
                        end
                    end else begin
                        hold_cnt      <= hold_cnt + 32'd1;
                        sample_strobe <= ((hold_cnt + 32'd1) == TEST_LAST);
                    end
                end

                IDLE, DONE: begin
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xor_training_sequencer.sv
// tb_xor_training_sequencer
// Directed bench for the XOR training sequencer. A cycle-indexed model
// derives every output from the phase boundaries (init, train, test, done)
// and the bench checks the whole output vector once per cycle.

module tb_xor_training_sequencer;

    logic        clk;
    logic        reset;
    logic        start;
    logic        start_s;
    logic [1:0]  pred_mode;

    logic [1:0]  predicted_m, expected_m;
    logic        reset_value_m, test_flag_m, x_input_m, y_input_m;
    logic        sample_strobe_m, busy_m, done_m, test_pass_m;
    logic [15:0] epoch_count_m;
    logic [2:0]  test_correct_m;

    logic [1:0]  predicted_s, expected_s;
    logic        reset_value_s, test_flag_s, x_input_s, y_input_s;
    logic        sample_strobe_s, busy_s, done_s, test_pass_s;
    logic [15:0] epoch_count_s;
    logic [2:0]  test_correct_s;

    int checks;
    int failures;

    logic [26:0] obs_m;
    logic [26:0] obs_s;
    logic [26:0] want;

    assign obs_m = {reset_value_m, test_flag_m, x_input_m, y_input_m, sample_strobe_m,
                    busy_m, done_m, epoch_count_m, test_correct_m, test_pass_m};
    assign obs_s = {reset_value_s, test_flag_s, x_input_s, y_input_s, sample_strobe_s,
                    busy_s, done_s, epoch_count_s, test_correct_s, test_pass_s};

    xor_training_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .start         (start),
        .predicted     (predicted_m),
        .expected      (expected_m),
        .reset_value   (reset_value_m),
        .test_flag     (test_flag_m),
        .x_input       (x_input_m),
        .y_input       (y_input_m),
        .sample_strobe (sample_strobe_m),
        .busy          (busy_m),
        .done          (done_m),
        .epoch_count   (epoch_count_m),
        .test_correct  (test_correct_m),
        .test_pass     (test_pass_m)
    );

    xor_training_sequencer #(
        .INIT_CYCLES (4),
        .HOLD_CYCLES (2),
        .EPOCHS      (1),
        .TEST_HOLD   (2)
    ) dut_s (
        .clk           (clk),
        .reset         (reset),
        .start         (start_s),
        .predicted     (predicted_s),
        .expected      (expected_s),
        .reset_value   (reset_value_s),
        .test_flag     (test_flag_s),
        .x_input       (x_input_s),
        .y_input       (y_input_s),
        .sample_strobe (sample_strobe_s),
        .busy          (busy_s),
        .done          (done_s),
        .epoch_count   (epoch_count_s),
        .test_correct  (test_correct_s),
        .test_pass     (test_pass_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Network stand-in: label is XOR of the sample; prediction depends on pred_mode.
    always_comb begin
        expected_m = {1'b0, x_input_m ^ y_input_m};
        expected_s = {1'b0, x_input_s ^ y_input_s};
        predicted_s = expected_s;
        case (pred_mode)
            2'd0:    predicted_m = expected_m;
            2'd1:    predicted_m = 2'b00;
            2'd2:    predicted_m = sample_strobe_m ? expected_m : ~expected_m;
            default: predicted_m = sample_strobe_m ? ~expected_m : expected_m;
        endcase
    end

    // Whether test sample i is classified correctly under a prediction mode.
    function automatic bit sample_ok(input int i, input logic [1:0] mode);
        if (mode == 2'd1) return (i == 0) || (i == 3);
        if (mode == 2'd3) return 1'b0;
        return 1'b1;
    endfunction

    // Expected output vector c cycles after start was sampled (c = 0: idle).
    function automatic logic [26:0] model(input int c, input int ic, input int hc,
                                          input int ec, input int tc, input logic [1:0] mode);
        logic rv, tf, xx, yy, st, bz, dn, tp;
        logic [15:0] ep;
        logic [2:0]  cor;
        logic [1:0]  sb;
        int t, u;
        rv = 0; tf = 0; xx = 0; yy = 0; st = 0; bz = 0; dn = 0; tp = 0;
        ep = '0; cor = '0; sb = '0;
        if (c <= 0) return '0;
        if (c <= ic) begin
            bz = 1; rv = 1;
        end else begin
            t = c - 1 - ic;
            if (t < 4 * hc * ec) begin
                bz = 1;
                sb = 2'((t / hc) % 4);
                xx = sb[0]; yy = sb[1];
                st = ((t % hc) == hc - 1);
                ep = 16'(t / (4 * hc));
            end else begin
                u  = t - 4 * hc * ec;
                ep = 16'(ec);
                if (u < 4 * tc) begin
                    bz = 1; tf = 1;
                    sb = 2'(u / tc);
                    xx = sb[0]; yy = sb[1];
                    st = ((u % tc) == tc - 1);
                    for (int i = 0; i < u / tc; i++) if (sample_ok(i, mode)) cor = cor + 3'd1;
                end else begin
                    dn = 1;
                    for (int i = 0; i < 4; i++) if (sample_ok(i, mode)) cor = cor + 3'd1;
                    tp = (cor == 3'd4);
                end
            end
        end
        return {rv, tf, xx, yy, st, bz, dn, ep, cor, tp};
    endfunction

    // Pulse start on the main DUT; returns #1 after the sampling edge (cycle 1).
    task automatic launch();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; start = 1'b1; start_s = 1'b1;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_m !== 27'd0) begin
                failures++;
                $display("[TB] FAIL reset_main edge=%0d got=%h want=%h", k, obs_m, 27'd0);
            end
            checks++;
            if (obs_s !== 27'd0) begin
                failures++;
                $display("[TB] FAIL reset_small edge=%0d got=%h want=%h", k, obs_s, 27'd0);
            end
        end
        reset = 1'b0; start = 1'b0; start_s = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk); #1;
            checks++;
            if (obs_m !== 27'd0) begin
                failures++;
                $display("[TB] FAIL reset_stays_idle k=%0d got=%h want=%h", k, obs_m, 27'd0);
            end
        end
    endtask

    task automatic test_default_sequence();
        pred_mode = 2'd0;
        launch();
        for (int c = 1; c <= 225; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            want = model(c, 4, 10, 5, 5, pred_mode);
            checks++;
            if (obs_m !== want) begin
                failures++;
                $display("[TB] FAIL default_seq cycle=%0d got=%h want=%h", c, obs_m, want);
            end
        end
    endtask

    task automatic test_start_ignored();
        pred_mode = 2'd0;
        launch();
        for (int c = 1; c <= 225; c++) begin
            if (c > 1) begin @(posedge clk); #1; start = 1'b0; end
            want = model(c, 4, 10, 5, 5, pred_mode);
            checks++;
            if (obs_m !== want) begin
                failures++;
                $display("[TB] FAIL start_ignored cycle=%0d got=%h want=%h", c, obs_m, want);
            end
            if (c == 2 || c == 50 || c == 210) start = 1'b1;
        end
    endtask

    task automatic test_mispredict();
        pred_mode = 2'd1;
        launch();
        for (int c = 1; c <= 225; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            want = model(c, 4, 10, 5, 5, pred_mode);
            checks++;
            if (obs_m !== want) begin
                failures++;
                $display("[TB] FAIL mispredict cycle=%0d got=%h want=%h", c, obs_m, want);
            end
        end
    endtask

    task automatic test_strobe_sampling();
        for (int m = 2; m <= 3; m++) begin
            pred_mode = 2'(m);
            launch();
            for (int c = 1; c <= 225; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                want = model(c, 4, 10, 5, 5, pred_mode);
                checks++;
                if (obs_m !== want) begin
                    failures++;
                    $display("[TB] FAIL strobe_sampling mode=%0d cycle=%0d got=%h want=%h",
                             m, c, obs_m, want);
                end
            end
        end
    endtask

    task automatic test_back_to_back();
        pred_mode = 2'd0;
        for (int run = 0; run < 2; run++) begin
            launch();
            for (int c = 1; c <= 230; c++) begin
                if (c > 1) begin @(posedge clk); #1; end
                want = model(c, 4, 10, 5, 5, pred_mode);
                checks++;
                if (obs_m !== want) begin
                    failures++;
                    $display("[TB] FAIL back_to_back run=%0d cycle=%0d got=%h want=%h",
                             run, c, obs_m, want);
                end
            end
        end
    endtask

    task automatic test_reset_mid_train();
        pred_mode = 2'd0;
        launch();
        for (int c = 1; c <= 100; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            want = model(c, 4, 10, 5, 5, pred_mode);
            checks++;
            if (obs_m !== want) begin
                failures++;
                $display("[TB] FAIL mid_train_pre cycle=%0d got=%h want=%h", c, obs_m, want);
            end
        end
        reset = 1'b1; start = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0; start = 1'b0;
        checks++;
        if (obs_m !== 27'd0) begin
            failures++;
            $display("[TB] FAIL mid_train_reset cycle=101 got=%h want=%h", obs_m, 27'd0);
        end
        @(posedge clk); #1;
        checks++;
        if (obs_m !== 27'd0) begin
            failures++;
            $display("[TB] FAIL mid_train_idle got=%h want=%h", obs_m, 27'd0);
        end
        launch();
        for (int c = 1; c <= 225; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            want = model(c, 4, 10, 5, 5, pred_mode);
            checks++;
            if (obs_m !== want) begin
                failures++;
                $display("[TB] FAIL mid_train_rerun cycle=%0d got=%h want=%h", c, obs_m, want);
            end
        end
    endtask

    task automatic test_short_params();
        start_s = 1'b1;
        @(posedge clk); #1;
        start_s = 1'b0;
        for (int c = 1; c <= 23; c++) begin
            if (c > 1) begin @(posedge clk); #1; end
            want = model(c, 4, 2, 1, 2, 2'd0);
            checks++;
            if (obs_s !== want) begin
                failures++;
                $display("[TB] FAIL short_params cycle=%0d got=%h want=%h", c, obs_s, want);
            end
        end
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        reset     = 1'b0;
        start     = 1'b0;
        start_s   = 1'b0;
        pred_mode = 2'd0;

        test_reset();
        test_short_params();
        test_default_sequence();
        test_start_ignored();
        test_mispredict();
        test_strobe_sampling();
        test_back_to_back();
        test_reset_mid_train();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
